// File: rtl/pass_request_gen.sv
// rtl/pass_request_gen.sv - pedestrian button synchronizer, debouncer and rate-limited pass pulse generator
// Optional pass counter built only when PASS_CNT_EN is defined; otherwise pass_cnt is tied to zero.
module pass_request_gen #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEB_CYCLES     = 16,
  parameter int HOLDOFF_CYCLES = 512,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  output logic             pass,
  output logic             pending,
  output logic [CNT_W-1:0] pass_cnt
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   btn_db;
  logic [DW-1:0]          dcnt;
  logic [HW-1:0]          hcnt;
  logic                   db_flip;
  logic                   db_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign db_flip = (s != btn_db) && (dcnt == DW'(DEB_CYCLES - 1));
  assign db_rise = db_flip && s;

  // A level change is accepted only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= 1'b0;
      dcnt   <= '0;
    end else if (s == btn_db) begin
      dcnt <= '0;
    end else if (db_flip) begin
      btn_db <= s;
      dcnt   <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending) state_d = ISSUE;
      ISSUE:   state_d = HOLD;
      HOLD:    if (hcnt == '0) state_d = pending ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pass is registered alongside the state so it is high exactly while in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pass    <= 1'b0;
    end else begin
      state_q <= state_d;
      pass    <= (state_d == ISSUE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
    end else if (state_q == ISSUE) begin
      hcnt <= HW'(HOLDOFF_CYCLES - 1);
    end else if ((state_q == HOLD) && (hcnt != '0)) begin
      hcnt <= hcnt - 1'b1;
    end
  end

  // Set has priority so a press landing on the ISSUE-exit edge is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (db_rise) begin
      pending <= 1'b1;
    end else if (state_q == ISSUE) begin
      pending <= 1'b0;
    end
  end

`ifdef PASS_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
    end else if (state_q == ISSUE) begin
      pass_cnt <= pass_cnt + 1'b1;
    end
  end
`else
  assign pass_cnt = '0;
`endif

endmodule

// File: tb/tb_pass_request_gen.sv
// tb/tb_pass_request_gen.sv - directed bench for pass_request_gen (SYNC 2, DEB 4, HOLDOFF 8, CNT_W 4)
module tb_pass_request_gen;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       pass;
  logic       pending;
  logic [3:0] pass_cnt;

  int errors = 0;
  int checks = 0;

  pass_request_gen #(
    .SYNC_STAGES(2),
    .DEB_CYCLES(4),
    .HOLDOFF_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .pass(pass),
    .pending(pending),
    .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_cnt(input int n);
`ifdef PASS_CNT_EN
    return 4'(n % 16);
`else
    return 4'(n) & 4'h0;
`endif
  endfunction

  // Press pattern with period 8: btn sampled high on the first hi_len edges of each period.
  function automatic logic pat(input int e, input int hi_len);
    return ((e - 1) % 8) < hi_len;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pass, pending, pass_cnt} !== 6'b0)
      $display("FAIL reset_async got=%b exp=0", {pass, pending, pass_cnt});
    for (int i = 0; i < 4; i++) begin
      btn = ~btn;
      @(posedge clk);
      #1;
      checks++;
      if ({pass, pending, pass_cnt} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=0", i, {pass, pending, pass_cnt});
      end
    end
    if ({pass, pending, pass_cnt} !== 6'b0 && checks == 1) errors++;
  endtask

  task automatic test_single_press();
    logic       ep;
    logic       eq;
    logic [3:0] ec;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      btn = 1'b1;
      @(posedge clk);
      #1;
      ep = (e == 7);
      eq = (e == 6 || e == 7);
      ec = exp_cnt(e >= 8 ? 1 : 0);
      checks++;
      if (pass !== ep) begin
        errors++;
        $display("FAIL single_pass e=%0d got=%b exp=%b", e, pass, ep);
      end
      checks++;
      if (pending !== eq) begin
        errors++;
        $display("FAIL single_pending e=%0d got=%b exp=%b", e, pending, eq);
      end
      checks++;
      if (pass_cnt !== ec) begin
        errors++;
        $display("FAIL single_cnt e=%0d got=%0d exp=%0d", e, pass_cnt, ec);
      end
    end
    btn = 1'b0;
  endtask

  task automatic test_glitch();
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      btn = pat(e, 3);
      @(posedge clk);
      #1;
      checks++;
      if ({pass, pending, pass_cnt} !== 6'b0) begin
        errors++;
        $display("FAIL glitch e=%0d got=%b exp=0", e, {pass, pending, pass_cnt});
      end
    end
    btn = 1'b0;
  endtask

  // Presses every 8 edges against a 9-edge pulse period; the rise at edge 62 lands on an ISSUE exit.
  task automatic test_back_to_back();
    int   pulses [8] = '{7, 16, 25, 34, 43, 52, 61, 70};
    int   plo    [7] = '{6, 14, 22, 30, 38, 46, 54};
    int   phi    [7] = '{7, 16, 25, 34, 43, 52, 70};
    logic ep;
    logic eq;
    int   nex;
    do_reset();
    for (int e = 1; e <= 90; e++) begin
      btn = (e <= 60) && pat(e, 4);
      @(posedge clk);
      #1;
      ep  = 1'b0;
      eq  = 1'b0;
      nex = 0;
      foreach (pulses[k]) begin
        if (pulses[k] == e) ep = 1'b1;
        if (pulses[k] + 1 <= e) nex++;
      end
      foreach (plo[k]) if (e >= plo[k] && e <= phi[k]) eq = 1'b1;
      checks++;
      if (pass !== ep) begin
        errors++;
        $display("FAIL b2b_pass e=%0d got=%b exp=%b", e, pass, ep);
      end
      checks++;
      if (pending !== eq) begin
        errors++;
        $display("FAIL b2b_pending e=%0d got=%b exp=%b", e, pending, eq);
      end
      checks++;
      if (pass_cnt !== exp_cnt(nex)) begin
        errors++;
        $display("FAIL b2b_cnt e=%0d got=%0d exp=%0d", e, pass_cnt, exp_cnt(nex));
      end
    end
  endtask

  task automatic test_counter_wrap();
    int   npulse = 0;
    int   last   = 0;
    logic prev   = 1'b0;
    do_reset();
    for (int e = 1; e <= 400; e++) begin
      btn = pat(e, 4);
      @(posedge clk);
      #1;
      if (prev) begin
        checks++;
        if (pass_cnt !== exp_cnt(npulse)) begin
          errors++;
          $display("FAIL wrap_cnt pulse=%0d got=%0d exp=%0d", npulse, pass_cnt, exp_cnt(npulse));
        end
        if (npulse == 17) break;
      end
      if (pass) begin
        checks++;
        if (prev) begin
          errors++;
          $display("FAIL wrap_width e=%0d got=2 cycles exp=1", e);
        end
        npulse++;
        if (npulse > 1) begin
          checks++;
          if (e - last != 9) begin
            errors++;
            $display("FAIL wrap_spacing e=%0d got=%0d exp=9", e, e - last);
          end
        end
        last = e;
      end
      prev = pass;
    end
    checks++;
    if (npulse != 17) begin
      errors++;
      $display("FAIL wrap_timeout got=%0d pulses exp=17", npulse);
    end
    btn = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      btn = pat(e, 4);
      @(posedge clk);
      #1;
    end
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre_pending got=%b exp=1", pending);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pass, pending, pass_cnt} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_async got=%b exp=0", {pass, pending, pass_cnt});
    end
    for (int i = 0; i < 4; i++) begin
      btn = ~btn;
      @(posedge clk);
      #1;
      checks++;
      if ({pass, pending, pass_cnt} !== 6'b0) begin
        errors++;
        $display("FAIL midrst_hold cyc=%0d got=%b exp=0", i, {pass, pending, pass_cnt});
      end
    end
    rst_n = 1'b1;
    btn   = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({pass, pending, pass_cnt} !== 6'b0) begin
        errors++;
        $display("FAIL midrst_after e=%0d got=%b exp=0", e, {pass, pending, pass_cnt});
      end
    end
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b1;
    btn   = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_back_to_back();
    test_counter_wrap();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
